// File: rtl/float_to_int.sv
// Multi-cycle IEEE-754 single to 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// stb/ack handshake on both sides, RISC-V rounding modes, saturation with NV/NX flags.
module float_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [2:0]  rm,
  input  logic        is_unsigned,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic        flag_nv,
  output logic        flag_nx
);

  typedef enum logic [2:0] {GET_A, UNPACK, ALIGN, ROUND, PACK, PUT_Z} state_t;

  state_t             state_q;
  logic [31:0]        a_q;
  logic [2:0]         rm_q;
  logic               uns_q;
  logic               s_q, nan_q, inf_q, ovf_q;
  logic signed [9:0]  e_q;
  logic [23:0]        m_q;
  logic [32:0]        mag_q;
  logic               g_q, st_q;
  logic               ack_q, stb_q, nv_q, nx_q;
  logic [31:0]        z_q;

  logic [32:0]        mag_d;
  logic               g_d, st_d, ovf_d;
  logic [47:0]        shr;
  logic [4:0]         sh;
  logic               inc;
  logic [31:0]        z_d, max_pos, max_neg;
  logic               nv_d, nx_d;

  // Right shifts place the mantissa above a 24-bit fraction field so guard and
  // sticky fall out of the same shifter; e=-1 is simply a 24-bit shift.
  always_comb begin
    mag_d = '0;
    g_d   = 1'b0;
    st_d  = 1'b0;
    ovf_d = 1'b0;
    shr   = '0;
    sh    = '0;
    if (e_q < -10'sd1) begin
      st_d = |m_q;
    end else if (e_q <= 10'sd23) begin
      sh    = 5'(10'sd23 - e_q);
      shr   = {m_q, 24'd0} >> sh;
      mag_d = {9'd0, shr[47:24]};
      g_d   = shr[23];
      st_d  = |shr[22:0];
    end else if (e_q <= 10'sd31) begin
      sh    = 5'(e_q - 10'sd23);
      mag_d = {9'd0, m_q} << sh;
    end else begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s_q & (g_q | st_q);
      3'b011:  inc = ~s_q & (g_q | st_q);
      3'b100:  inc = g_q;
      default: inc = g_q & (st_q | mag_q[0]);
    endcase
  end

  always_comb begin
    max_pos = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    max_neg = uns_q ? 32'h0000_0000 : 32'h8000_0000;
    z_d  = '0;
    nv_d = 1'b1;
    nx_d = 1'b0;
    if (nan_q)                                        z_d = max_pos;
    else if ((inf_q | ovf_q) & ~s_q)                  z_d = max_pos;
    else if (inf_q | ovf_q)                           z_d = max_neg;
    else if (~uns_q & ~s_q & (mag_q > 33'h0_7FFF_FFFF)) z_d = 32'h7FFF_FFFF;
    else if (~uns_q &  s_q & (mag_q > 33'h0_8000_0000)) z_d = 32'h8000_0000;
    else if ( uns_q & ~s_q & (mag_q > 33'h0_FFFF_FFFF)) z_d = 32'hFFFF_FFFF;
    else if ( uns_q &  s_q & (mag_q != '0))           z_d = '0;
    else begin
      z_d  = s_q ? -mag_q[31:0] : mag_q[31:0];
      nv_d = 1'b0;
      nx_d = g_q | st_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      z_q     <= '0;
      nv_q    <= 1'b0;
      nx_q    <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          ack_q <= 1'b1;
          if (input_a_stb && ack_q) begin
            a_q     <= input_a;
            rm_q    <= rm;
            uns_q   <= is_unsigned;
            ack_q   <= 1'b0;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          s_q     <= a_q[31];
          e_q     <= $signed({2'b00, a_q[30:23]}) - 10'sd127;
          m_q     <= {|a_q[30:23], a_q[22:0]};
          nan_q   <= (&a_q[30:23]) & (|a_q[22:0]);
          inf_q   <= (&a_q[30:23]) & ~(|a_q[22:0]);
          state_q <= ALIGN;
        end
        ALIGN: begin
          mag_q   <= mag_d;
          g_q     <= g_d;
          st_q    <= st_d;
          ovf_q   <= ovf_d;
          state_q <= ROUND;
        end
        ROUND: begin
          mag_q   <= mag_q + {32'd0, inc};
          state_q <= PACK;
        end
        PACK: begin
          z_q     <= z_d;
          nv_q    <= nv_d;
          nx_q    <= nx_d;
          stb_q   <= 1'b1;
          state_q <= PUT_Z;
        end
        PUT_Z: begin
          if (output_z_ack) begin
            stb_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = z_q;
  assign flag_nv      = nv_q;
  assign flag_nx      = nx_q;

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int: directed vector table, handshake/reset sequences,
// and random operands checked against an exact-arithmetic reference model.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [2:0]  rm;
  logic        is_unsigned;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;
  logic        flag_nv;
  logic        flag_nx;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .rm           (rm),
    .is_unsigned  (is_unsigned),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .flag_nv      (flag_nv),
    .flag_nx      (flag_nx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] z;
    logic        nv;
    logic        nx;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exact model: value = m * 2^sh, remainder compared against one half ulp of the integer.
  function automatic vec_t model(input logic [31:0] a, input logic [2:0] r, input logic u);
    vec_t v;
    longint unsigned m, ip, rem, half;
    longint val;
    int ex, sh;
    logic neg, up;
    v.a = a; v.rm = r; v.uns = u; v.nv = 1'b0; v.nx = 1'b0; v.z = '0;
    ex  = int'(a[30:23]);
    neg = a[31];
    if (ex == 255) begin
      v.nv = 1'b1;
      if (a[22:0] != 0 || !neg) v.z = u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      else                      v.z = u ? 32'h0000_0000 : 32'h8000_0000;
      return v;
    end
    m  = {40'd0, ex != 0, a[22:0]};
    sh = (ex == 0 ? 1 : ex) - 150;
    if (sh >= 40) begin
      ip = 64'd1 << 40; rem = 0; half = 1;
    end else if (sh >= 0) begin
      ip = m << sh; rem = 0; half = 1;
    end else if (-sh <= 40) begin
      ip   = m >> (-sh);
      rem  = m & ((64'd1 << (-sh)) - 1);
      half = 64'd1 << (-sh - 1);
    end else begin
      ip = 0; rem = m; half = 64'd1 << 62;
    end
    case (r)
      3'd1:    up = 1'b0;
      3'd2:    up = neg && rem != 0;
      3'd3:    up = !neg && rem != 0;
      3'd4:    up = rem >= half;
      default: up = (rem > half) || (rem == half && ip[0]);
    endcase
    ip  = ip + (up ? 64'd1 : 64'd0);
    val = neg ? -longint'(ip) : longint'(ip);
    if (!u) begin
      if (val > 64'sd2147483647)       begin v.z = 32'h7FFF_FFFF; v.nv = 1'b1; end
      else if (val < -64'sd2147483648) begin v.z = 32'h8000_0000; v.nv = 1'b1; end
      else begin v.z = val[31:0]; v.nx = rem != 0; end
    end else begin
      if (val > 64'sd4294967295)       begin v.z = 32'hFFFF_FFFF; v.nv = 1'b1; end
      else if (val < 0)                begin v.z = 32'h0000_0000; v.nv = 1'b1; end
      else begin v.z = val[31:0]; v.nx = rem != 0; end
    end
    return v;
  endfunction

  task automatic convert(input logic [31:0] a, input logic [2:0] r, input logic u,
                         output logic [31:0] z, output logic nv, output logic nx);
    int budget, lat;
    budget = 0;
    @(negedge clk);
    while (!input_a_ack && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("ack_wait", {33'd0, input_a_ack}, 34'd1);
    input_a = a; rm = r; is_unsigned = u; input_a_stb = 1'b1;
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    lat = 0;
    while (!output_z_stb && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 34'(lat), 34'd4);
    z = output_z; nv = flag_nv; nx = flag_nx;
    @(negedge clk) output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    check("stb_drop", {33'd0, output_z_stb}, 34'd0);
  endtask

  vec_t        vecs[$];
  vec_t        e;
  logic [31:0] z;
  logic        nv, nx;
  logic [31:0] ra;
  logic [7:0]  rex;

  initial begin
    vecs = '{
      '{32'h3FC00000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h3FC00000, 3'd1, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'h3FC00000, 3'd2, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'h3FC00000, 3'd3, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h3FC00000, 3'd4, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h40200000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h40200000, 3'd4, 1'b0, 32'h00000003, 1'b0, 1'b1},
      '{32'h40200000, 3'd5, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'hBFC00000, 3'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1},
      '{32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1},
      '{32'h00000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{32'h3F000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1},
      '{32'hBE99999A, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'hBFC00000, 3'd1, 1'b1, 32'h00000000, 1'b1, 1'b0},
      '{32'h4F000000, 3'd0, 1'b1, 32'h80000000, 1'b0, 1'b0},
      '{32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0},
      '{32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hCF000000, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0},
      '{32'h501502F9, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'h7F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
      '{32'hFF800000, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0},
      '{32'h00000001, 3'd3, 1'b0, 32'h00000001, 1'b0, 1'b1},
      '{32'h00000001, 3'd1, 1'b0, 32'h00000000, 1'b0, 1'b1}
    };

    rst = 1'b1; input_a = '0; input_a_stb = 1'b0; rm = '0; is_unsigned = 1'b0; output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {input_a_ack, output_z_stb, output_z}, 34'd0);
    check("reset_flags", {32'd0, flag_nv, flag_nx}, 34'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("ack_after_reset", {33'd0, input_a_ack}, 34'd1);

    foreach (vecs[i]) begin
      convert(vecs[i].a, vecs[i].rm, vecs[i].uns, z, nv, nx);
      check($sformatf("vec%0d_%h", i, vecs[i].a), {z, nv, nx}, {vecs[i].z, vecs[i].nv, vecs[i].nx});
    end

    // Output held under back-pressure: 1.5 RUP -> 2, NX.
    @(negedge clk);
    input_a = 32'h3FC00000; rm = 3'd3; is_unsigned = 1'b0; input_a_stb = 1'b1;
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    repeat (4) @(posedge clk);
    for (int unsigned k = 0; k < 10; k++) begin
      #1;
      check("stall_hold", {output_z_stb, input_a_ack, output_z[31:2]}, {1'b1, 1'b0, 30'd0});
      check("stall_data", {output_z, flag_nv, flag_nx}, {32'd2, 1'b0, 1'b1});
      @(posedge clk);
    end
    @(negedge clk) output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;

    // Reset landing while the converter sits in align.
    @(negedge clk);
    while (!input_a_ack) @(negedge clk);
    input_a = 32'h501502F9; rm = 3'd0; input_a_stb = 1'b1;
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_stb", {32'd0, output_z_stb, input_a_ack}, 34'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("rst_mid_ack", {32'd0, output_z_stb, input_a_ack}, 34'd1);
    convert(32'h40200000, 3'd4, 1'b0, z, nv, nx);
    check("after_rst_conv", {z, nv, nx}, {32'd3, 1'b0, 1'b1});

    for (int unsigned i = 0; i < 400; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0, 1: begin rex = 8'($urandom_range(100, 165)); ra[30:23] = rex; end
        2:    ra[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: ;
      endcase
      e = model(ra, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      convert(e.a, e.rm, e.uns, z, nv, nx);
      check($sformatf("rand_%h_rm%0d_u%0d", e.a, e.rm, e.uns), {z, nv, nx}, {e.z, e.nv, e.nx});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
